// File: rtl/n_piso_tx.sv
// Parallel-in, serial-out transmitter. Accepts an N-bit word over a
// valid/ready handshake and shifts it out one bit per enabled clock.
// q, q_valid, busy and done are registered; load_ready is combinational.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no frame in flight; load_ready high, q/q_valid low
//   SHIFT | frame in flight; q shows the current bit, held until shift_en
module n_piso_tx #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         q,
  output logic         q_valid,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    sreg, sreg_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            done_nxt;
  logic            q_nxt;

  // Bit sitting at the output end of the shift register.
  function automatic logic out_bit(input logic [N-1:0] v);
    return MSB_FIRST ? v[N-1] : v[0];
  endfunction

  // Held low during reset so a word offered while reset releases is not
  // taken until the first edge with reset low.
  assign load_ready = (state == IDLE) && !reset;

  // Next-state logic: load, shift with zero fill, and terminal-count exit.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          sreg_nxt  = din;
          cnt_nxt   = CW'(N - 1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (cnt == '0) begin
            sreg_nxt  = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            sreg_nxt = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            cnt_nxt  = cnt - CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // q is registered from the next shift-register value so the new bit
    // appears in the same cycle the register moves.
    q_nxt = (state_nxt == SHIFT) && out_bit(sreg_nxt);
  end

  // State, datapath and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      cnt     <= cnt_nxt;
      q       <= q_nxt;
      q_valid <= (state_nxt == SHIFT);
      busy    <= (state_nxt == SHIFT);
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_n_piso_tx.sv
// Bench for n_piso_tx: three instances (N=8 MSB-first, N=8 LSB-first, N=1)
// share one stimulus stream and are compared every cycle against a
// word/bit-position model, plus directed literal checks.
module tb_n_piso_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       load_valid;
  logic       shift_en;
  logic [2:0] lr, qq, qv, bz, dn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  n_piso_tx #(.N(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(lr[0]), .shift_en(shift_en), .q(qq[0]), .q_valid(qv[0]),
    .busy(bz[0]), .done(dn[0]));

  n_piso_tx #(.N(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
    .load_ready(lr[1]), .shift_en(shift_en), .q(qq[1]), .q_valid(qv[1]),
    .busy(bz[1]), .done(dn[1]));

  n_piso_tx #(.N(1), .MSB_FIRST(1'b1)) u_one (
    .clk(clk), .reset(reset), .din(din[0:0]), .load_valid(load_valid),
    .load_ready(lr[2]), .shift_en(shift_en), .q(qq[2]), .q_valid(qv[2]),
    .busy(bz[2]), .done(dn[2]));

  // Model: a frame is a stored word plus how many bits have been consumed.
  logic [7:0] mw   [3];
  int         mpos [3];
  bit         mbusy[3];
  bit         mdone[3];

  function automatic int nbits(input int k);
    return (k == 2) ? 1 : 8;
  endfunction

  function automatic bit msbf(input int k);
    return (k != 1);
  endfunction

  function automatic logic exp_bit(input int k);
    if (!mbusy[k]) return 1'b0;
    return msbf(k) ? mw[k][nbits(k) - 1 - mpos[k]] : mw[k][mpos[k]];
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      mw[k] = '0; mpos[k] = 0; mbusy[k] = 0; mdone[k] = 0;
    end
  end

  // Model update on each edge; reset discards any frame at once.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        mbusy[k] = 0; mdone[k] = 0; mpos[k] = 0;
      end else if (mbusy[k]) begin
        mdone[k] = 0;
        if (shift_en) begin
          mpos[k] = mpos[k] + 1;
          if (mpos[k] == nbits(k)) begin
            mbusy[k] = 0; mdone[k] = 1;
          end
        end
      end else begin
        mdone[k] = 0;
        if (load_valid) begin
          mw[k] = din; mpos[k] = 0; mbusy[k] = 1;
        end
      end
    end
  end

  // Per-cycle compare at the falling edge: {load_ready,q,q_valid,busy,done}.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [4:0] got, exp;
      got = {lr[k], qq[k], qv[k], bz[k], dn[k]};
      exp = {(!mbusy[k] && !reset), exp_bit(k), mbusy[k], mbusy[k], mdone[k]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cmp inst%0d t=%0t got %b expected %b", k, $time, got, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] w;
  logic [7:0] col;
  int         ncol;
  bit         finished;
  bit         pat [4];

  initial begin
    reset = 1'b1; din = 8'hC4; load_valid = 1'b1; shift_en = 1'b1;
    #2;
    chk("reset_outputs", {3'b0, qq[0], qv[0], bz[0], dn[0], lr[0]}, 8'h00);
    tick(); tick();

    // Reset release with load_valid already high: accept at next edge.
    reset = 1'b0;
    chk("no_accept_in_reset", {7'b0, bz[0]}, 8'h00);
    tick();
    load_valid = 1'b0;
    w = 8'hC4;
    for (int i = 0; i < 8; i++) begin
      chk("msb_C4_bit", {6'b0, qv[0], qq[0]}, {6'b0, 1'b1, w[7 - i]});
      chk("lsb_C4_bit", {6'b0, qv[1], qq[1]}, {6'b0, 1'b1, w[i]});
      tick();
    end
    chk("C4_done", {5'b0, lr[0], dn[1], dn[0]}, 8'h07);

    // load_valid held through a frame: second word waits for the done cycle.
    din = 8'hF0; load_valid = 1'b1;
    tick();
    din = 8'h0F;
    w = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      chk("busy_ignore_bit", {6'b0, lr[0], qq[0]}, {7'b0, w[7 - i]});
      tick();
    end
    chk("busy_ignore_done", {6'b0, lr[0], dn[0]}, 8'h03);
    tick();
    chk("second_word_first_bit", {6'b0, qv[0], qq[0]}, 8'h02);
    load_valid = 1'b0;
    repeat (10) tick();

    // Stalled shifting: bits held while shift_en is low.
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    din = 8'hC4; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    col = '0; ncol = 0; finished = 0;
    for (int i = 0; i < 100 && !finished; i++) begin
      shift_en = pat[i % 4];
      if (qv[0] && shift_en) begin
        col = {col[6:0], qq[0]};
        ncol++;
      end
      tick();
      if (dn[0]) finished = 1;
    end
    chk("stall_finished", {7'b0, finished}, 8'h01);
    chk("stall_word", col, 8'hC4);
    chk("stall_count", 8'(ncol), 8'd8);
    shift_en = 1'b1;
    repeat (3) tick();

    // Reset between edges mid-frame.
    din = 8'hAA; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick(); tick();
    #1 reset = 1'b1;
    #1;
    chk("async_abort", {5'b0, qq[0], qv[0], bz[0]}, 8'h00);
    tick();
    chk("abort_no_done", {7'b0, dn[0]}, 8'h00);
    reset = 1'b0;
    din = 8'h55; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    w = 8'h55;
    for (int i = 0; i < 8; i++) begin
      chk("after_reset_55_bit", {6'b0, qv[0], qq[0]}, {6'b0, 1'b1, w[7 - i]});
      tick();
    end
    repeat (2) tick();

    // N=1 back-to-back words 1 then 0.
    din = 8'h01; load_valid = 1'b1;
    tick();
    din = 8'h00;
    chk("n1_first", {6'b0, qv[2], qq[2]}, 8'h03);
    tick();
    chk("n1_done_gap", {6'b0, lr[2], dn[2]}, 8'h03);
    tick();
    chk("n1_second", {6'b0, qv[2], qq[2]}, 8'h02);
    load_valid = 1'b0;
    repeat (3) tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      din        = 8'($urandom);
      load_valid = ($urandom_range(0, 2) != 0);
      shift_en   = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/n_piso_tx.md
Name: n_piso_tx

Overview:
- Parallel-in, serial-out shift register transmitter: the sending end of the library's serial shift chains.
- Accepts an N-bit word through a valid/ready handshake and emits it one bit per enabled clock on a single serial line, with a per-bit valid qualifier.
- Drives the `d` input of downstream serial-in shift registers or serial links.
- Shift pacing comes from an external enable strobe, so a slower bit clock can be derived from `clk`.

Parameters:
N, 8, word width in bits; legal range N >= 1.
MSB_FIRST, 1, 1 = bit N-1 transmitted first; 0 = bit 0 transmitted first.

Ports:
clk  input  1  single clock; all state changes on posedge.
reset  input  1  asynchronous, active-high reset; clears all state immediately.
din  input  N  parallel word to transmit; sampled only on an accepted load.
load_valid  input  1  producer has a word on din.
load_ready  output  1  block can accept a word this cycle.
shift_en  input  1  advance-one-bit strobe; sampled on posedge while busy.
q  output  1  serial data out, registered.
q_valid  output  1  q carries a valid frame bit this cycle.
busy  output  1  frame in progress (state SHIFT).
done  output  1  one-cycle pulse after the last bit has been consumed.

Behaviour:
- Reset (asynchronous, while reset=1):
  - state=IDLE; shift register=0; bit counter=0.
  - q=0, q_valid=0, busy=0, done=0.
  - load_ready=0 while reset is high.
- States: IDLE, SHIFT. Registered outputs q, q_valid, busy and done derive from state and registers only.
- load_ready = (state==IDLE) && !reset. It is combinational and never depends on load_valid.
- IDLE:
  - Accept occurs at a posedge where load_valid && load_ready.
  - On accept: capture din into the shift register, counter=N-1, go to SHIFT.
  - The first bit appears on q in the cycle immediately after the accept edge; q_valid=1 and busy=1 from that cycle.
  - Load latency is 1 cycle.
- SHIFT:
  - q holds the current bit: sreg[N-1] if MSB_FIRST, else sreg[0].
  - q_valid=1, busy=1.
  - posedge with shift_en=0: no change; the current bit is held indefinitely.
  - posedge with shift_en=1 and counter!=0: shift toward the output end, zero-fill, counter decrements, q presents the next bit.
  - posedge with shift_en=1 and counter==0: the last bit is consumed; go to IDLE with q=0, q_valid=0, busy=0, done=1 for exactly one cycle.
- done clears on the next posedge unconditionally.
- Back-to-back frames: load_ready rises in the done cycle. A word accepted at that edge puts its first bit on q in the following cycle. The minimum inter-frame gap is one idle cycle (the done cycle).
- load_valid during SHIFT is ignored; din is not sampled and the frame is unaffected.
- shift_en in IDLE is ignored.
- Counter width is max(1,$clog2(N)) bits.
- N=1: counter stays 0, so one enabled edge finishes the frame.
- Reset asserted mid-frame aborts immediately: q=0 and q_valid=0 asynchronously, no done pulse, and the partial frame is discarded.
- Reset deasserting in the same cycle as load_valid=1: no accept at that edge, because load_ready was 0 during reset. The accept happens at the first posedge with reset low.

Test Plan:
- N=8, MSB_FIRST=1: load din=8'hC4 with shift_en held at 1 → q over cycles 1..8 after accept = 1,1,0,0,0,1,0,0 with q_valid=1; done=1 at cycle 9; load_ready=1 at cycle 9.
- N=8, MSB_FIRST=0: load 8'hC4 with shift_en=1 → q = 0,0,1,0,0,0,1,1; done on the 9th cycle.
- Stall: 8'hC4 MSB-first with shift_en pattern 1,0,0,1,... → each bit held during shift_en=0 cycles; done exactly after the 8th enabled edge; total bits out = 8.
- Ignore during busy: accept 8'hF0, then drive din=8'h0F with load_valid=1 throughout the frame → serial output still 1,1,1,1,0,0,0,0; load_ready=0 during bits 1..8. The second word is accepted at the done cycle and its first bit is 0.
- Reset mid-frame: assert reset after bit 3 of 8'hAA, asynchronously between edges → q=0 and q_valid=0 before the next edge, no done pulse. After release, loading 8'h55 yields 0,1,0,1,0,1,0,1.
- N=1: load 1'b1 → q=1 for one cycle with shift_en=1; done in the next cycle; accepting back-to-back words 1, 0 gives q=1, (gap), 0.
